// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: writable instruction memory, start/halt
// handshake, zero/sign/carry flags, conditional branches and a debug read port.
module cpu_core_param #(
  parameter int DW = 8,
  parameter int RB = 2,
  parameter int AW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  im_we,
  input  logic [AW-1:0]         im_addr,
  input  logic [4+2*RB+DW-1:0]  im_wdata,
  input  logic                  start,
  output logic                  busy,
  output logic                  halted,
  output logic [AW-1:0]         pc,
  output logic                  zf,
  output logic                  sf,
  output logic                  cf,
  input  logic [RB-1:0]         dbg_sel,
  output logic [DW-1:0]         dbg_data,
  output logic [15:0]           retired
);

  localparam int IW = 4 + 2*RB + DW;
  localparam int NR = 2**RB;
  localparam int ND = 2**AW;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_JS  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   regs_q [NR];
  logic [DW-1:0]   regs_d [NR];
  logic            zf_q, zf_d, sf_q, sf_d, cf_q, cf_d;
  logic [15:0]     retired_q, retired_d;
  logic [IW-1:0]   imem_q [ND];

  logic [3:0]      op_s;
  logic [RB-1:0]   rd_s, rs_s;
  logic [DW-1:0]   imm_s, a_s, b_s, result_s;
  logic [DW:0]     sum_s, diff_s, alu_ext_s;
  logic            alu_cf_s, reg_wr_s, flag_upd_s, take_s, imem_we_s;

  assign op_s  = ir_q[IW-1 -: 4];
  assign rd_s  = ir_q[DW+2*RB-1 -: RB];
  assign rs_s  = ir_q[DW+RB-1 -: RB];
  assign imm_s = ir_q[DW-1:0];
  assign a_s   = regs_q[rd_s];
  assign b_s   = regs_q[rs_s];

  // Carry and borrow both fall out of the extra top bit of a DW+1 result.
  assign sum_s    = {1'b0, a_s} + {1'b0, b_s};
  assign diff_s   = {1'b0, a_s} - {1'b0, b_s};
  assign result_s = alu_ext_s[DW-1:0];

  assign imem_we_s = im_we & ~rst & ((state_q == S_IDLE) | (state_q == S_HALT));

  // ALU result, carry and write/flag-update strobes for the instruction in ir
  always_comb begin
    alu_ext_s  = {1'b0, a_s};
    alu_cf_s   = cf_q;
    reg_wr_s   = 1'b0;
    flag_upd_s = 1'b0;
    case (op_s)
      OP_LDI: begin alu_ext_s = {1'b0, imm_s}; reg_wr_s = 1'b1; end
      OP_MOV: begin alu_ext_s = {1'b0, b_s};   reg_wr_s = 1'b1; end
      OP_ADD: begin
        alu_ext_s = sum_s;  alu_cf_s = sum_s[DW];  reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_SUB: begin
        alu_ext_s = diff_s; alu_cf_s = diff_s[DW]; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_AND: begin
        alu_ext_s = {1'b0, a_s & b_s}; alu_cf_s = 1'b0; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_OR: begin
        alu_ext_s = {1'b0, a_s | b_s}; alu_cf_s = 1'b0; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_XOR: begin
        alu_ext_s = {1'b0, a_s ^ b_s}; alu_cf_s = 1'b0; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_SHL: begin
        alu_ext_s = {a_s, 1'b0}; alu_cf_s = a_s[DW-1]; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_SHR: begin
        alu_ext_s = {2'b00, a_s[DW-1:1]}; alu_cf_s = a_s[0]; reg_wr_s = 1'b1; flag_upd_s = 1'b1;
      end
      OP_CMP: begin
        alu_ext_s = diff_s; alu_cf_s = diff_s[DW]; flag_upd_s = 1'b1;
      end
      default: begin end
    endcase
  end

  // Branch decision, using the flags as they stood before this instruction
  always_comb begin
    take_s = 1'b0;
    case (op_s)
      OP_JMP:  take_s = 1'b1;
      OP_JZ:   take_s = zf_q;
      OP_JNZ:  take_s = ~zf_q;
      OP_JS:   take_s = sf_q;
      default: take_s = 1'b0;
    endcase
  end

  // Next-state logic of the control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_FETCH;
        else       state_d = state_q;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (op_s == OP_HLT) state_d = S_HALT;
        else                state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy   = 1'b0;
    halted = 1'b0;
    case (state_q)
      S_FETCH, S_EXEC: busy   = 1'b1;
      S_HALT:          halted = 1'b1;
      default: begin busy = 1'b0; halted = 1'b0; end
    endcase
  end

  // Architectural state updates: pc, ir, registers, flags, retire counter
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    cf_d      = cf_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = '0;
          retired_d = 16'h0000;
        end else begin
          pc_d      = pc_q;
          retired_d = retired_q;
        end
      end
      S_FETCH: ir_d = imem_q[pc_q];
      S_EXEC: begin
        if (retired_q != 16'hFFFF) retired_d = retired_q + 16'h0001;
        else                       retired_d = retired_q;
        if (reg_wr_s) regs_d[rd_s] = result_s;
        else          regs_d[rd_s] = regs_q[rd_s];
        if (flag_upd_s) begin
          zf_d = (result_s == '0);
          sf_d = result_s[DW-1];
          cf_d = alu_cf_s;
        end else begin
          zf_d = zf_q;
          sf_d = sf_q;
          cf_d = cf_q;
        end
        if (op_s == OP_HLT) pc_d = pc_q;
        else if (take_s)    pc_d = imm_s[AW-1:0];
        else                pc_d = pc_q + AW'(1);
      end
      default: begin end
    endcase
  end

  // State register and architectural flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      cf_q      <= 1'b0;
      retired_q <= 16'h0000;
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      cf_q      <= cf_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  // Instruction memory keeps its contents across reset; writes only while stopped
  always_ff @(posedge clk) begin
    if (imem_we_s) imem_q[im_addr] <= im_wdata;
  end

  assign pc       = pc_q;
  assign zf       = zf_q;
  assign sf       = sf_q;
  assign cf       = cf_q;
  assign retired  = retired_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: directed programs plus random
// programs compared against an instruction-level reference model.
module tb_cpu_core_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, im_we, start, busy, halted, zf, sf, cf;
  logic [3:0]  im_addr, pc;
  logic [15:0] im_wdata, retired;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  logic        im_we_w, start_w, busy_w, halted_w, zf_w, sf_w, cf_w;
  logic [5:0]  im_addr_w, pc_w;
  logic [25:0] im_wdata_w;
  logic [2:0]  dbg_sel_w;
  logic [15:0] dbg_data_w, retired_w;

  cpu_core_param dut (
    .clk(clk), .rst(rst), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .start(start), .busy(busy), .halted(halted), .pc(pc), .zf(zf), .sf(sf), .cf(cf),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired(retired)
  );

  cpu_core_param #(.DW(16), .RB(3), .AW(6)) dut_w (
    .clk(clk), .rst(rst), .im_we(im_we_w), .im_addr(im_addr_w), .im_wdata(im_wdata_w),
    .start(start_w), .busy(busy_w), .halted(halted_w), .pc(pc_w), .zf(zf_w), .sf(sf_w),
    .cf(cf_w), .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w), .retired(retired_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (8-bit data, 4 registers, 16-word memory)
  logic [15:0] m_mem [16];
  int          m_reg [4];
  bit          m_zf, m_sf, m_cf;
  int          m_pc, m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic load(input logic [3:0] a, input logic [15:0] w);
    im_we = 1'b1; im_addr = a; im_wdata = w;
    m_mem[a] = w;
    tick();
    im_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) m_reg[r] = 0;
    m_zf = 0; m_sf = 0; m_cf = 0; m_pc = 0; m_ret = 0;
  endtask

  // Executes the program in m_mem from address 0 until HLT, instruction by instruction.
  task automatic model_run();
    int p, guard, op, rd, rs, imm, a, b, r, np;
    bit done, upd;
    p = 0; guard = 0; done = 0; m_ret = 0;
    while (!done && guard < 1000) begin
      op  = int'(m_mem[p][15:12]);
      rd  = int'(m_mem[p][11:10]);
      rs  = int'(m_mem[p][9:8]);
      imm = int'(m_mem[p][7:0]);
      a = m_reg[rd]; b = m_reg[rs]; r = 0; upd = 0;
      np = (p + 1) % 16;
      m_ret++; guard++;
      case (op)
        1:  m_reg[rd] = imm;
        2:  m_reg[rd] = b;
        3:  begin r = a + b; m_cf = (r > 255); r = r % 256; m_reg[rd] = r; upd = 1; end
        4:  begin m_cf = (b > a); r = (a - b + 256) % 256; m_reg[rd] = r; upd = 1; end
        5:  begin r = a & b; m_cf = 0; m_reg[rd] = r; upd = 1; end
        6:  begin r = a | b; m_cf = 0; m_reg[rd] = r; upd = 1; end
        7:  begin r = a ^ b; m_cf = 0; m_reg[rd] = r; upd = 1; end
        8:  begin m_cf = (a >= 128); r = (a * 2) % 256; m_reg[rd] = r; upd = 1; end
        9:  begin m_cf = (a % 2 == 1); r = a / 2; m_reg[rd] = r; upd = 1; end
        10: begin m_cf = (b > a); r = (a - b + 256) % 256; upd = 1; end
        11: np = imm % 16;
        12: if (m_zf)  np = imm % 16;
        13: if (!m_zf) np = imm % 16;
        14: if (m_sf)  np = imm % 16;
        15: begin done = 1; np = p; end
        default: ;
      endcase
      if (upd) begin
        m_zf = (r == 0);
        m_sf = (r >= 128);
      end
      p = np;
    end
    m_pc = p;
  endtask

  task automatic check_vs_model(input string tag);
    model_run();
    for (int r = 0; r < 4; r++) begin
      dbg_sel = r[1:0];
      #1;
      chk($sformatf("%s_r%0d", tag, r), dbg_data, m_reg[r]);
    end
    chk({tag, "_zf"}, zf, m_zf);
    chk({tag, "_sf"}, sf, m_sf);
    chk({tag, "_cf"}, cf, m_cf);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_retired"}, retired, m_ret);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  // Straight-line random program with forward-only branches, ending in HLT.
  task automatic gen_random_prog();
    int k, tgt, hi;
    logic [3:0] op;
    logic [7:0] imm;
    for (int i = 0; i < 15; i++) begin
      k = $urandom_range(0, 9);
      imm = 8'($urandom_range(0, 255));
      if (k < 2) op = 4'h1;
      else if (k < 8) op = 4'($urandom_range(2, 10));
      else if (k == 8) begin
        op  = 4'($urandom_range(11, 14));
        tgt = $urandom_range(i + 1, 15);
        hi  = $urandom_range(0, 15);
        imm = {4'(hi), 4'(tgt)};
      end else op = 4'h0;
      load(4'(i), ins(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), imm));
    end
    load(4'hF, ins(4'hF, 2'd0, 2'd0, 8'h00));
  endtask

  initial begin
    int cyc;
    logic [7:0] v;
    rst = 1'b1; im_we = 1'b0; start = 1'b0; im_addr = 4'h0; im_wdata = 16'h0000; dbg_sel = 2'd0;
    im_we_w = 1'b0; start_w = 1'b0; im_addr_w = 6'h00; im_wdata_w = 26'h0; dbg_sel_w = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {zf, sf, cf}, 0);
    chk("rst_retired", retired, 0);
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), v);
      chk($sformatf("rst_dbg_r%0d", r), v, 0);
    end
    dbg_sel_w = 3'd7; #1;
    chk("rst_w_dbg", dbg_data_w, 0);
    chk("rst_w_busy", busy_w, 0);

    // basic add program
    load(4'h0, ins(4'h1, 2'd0, 2'd0, 8'h05));
    load(4'h1, ins(4'h1, 2'd1, 2'd0, 8'h03));
    load(4'h2, ins(4'h3, 2'd0, 2'd1, 8'h00));
    load(4'h3, ins(4'hF, 2'd0, 2'd0, 8'h00));
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_pc0", pc, 0);
    chk("t1_ret0", retired, 0);
    wait_halt(100, cyc);
    chk("t1_cycles", cyc, 8);
    read_reg(2'd0, v);
    chk("t1_r0", v, 8'h08);
    chk("t1_flags", {zf, sf, cf}, 3'b000);
    chk("t1_retired", retired, 4);
    chk("t1_pc", pc, 3);
    check_vs_model("t1");

    // carry then borrow
    load(4'h0, ins(4'h1, 2'd0, 2'd0, 8'hFF));
    load(4'h1, ins(4'h1, 2'd1, 2'd0, 8'h01));
    load(4'h2, ins(4'h3, 2'd0, 2'd1, 8'h00));
    load(4'h3, ins(4'hF, 2'd0, 2'd0, 8'h00));
    do_start();
    wait_halt(100, cyc);
    read_reg(2'd0, v);
    chk("carry_r0", v, 8'h00);
    chk("carry_zf", zf, 1);
    chk("carry_cf", cf, 1);
    check_vs_model("carry");
    load(4'h3, ins(4'h4, 2'd0, 2'd1, 8'h00));
    load(4'h4, ins(4'hF, 2'd0, 2'd0, 8'h00));
    do_start();
    wait_halt(100, cyc);
    read_reg(2'd0, v);
    chk("borrow_r0", v, 8'hFF);
    chk("borrow_flags", {zf, sf, cf}, 3'b011);
    check_vs_model("borrow");

    // countdown loop
    load(4'h0, ins(4'h1, 2'd0, 2'd0, 8'h03));
    load(4'h1, ins(4'h1, 2'd1, 2'd0, 8'h01));
    load(4'h2, ins(4'h4, 2'd0, 2'd1, 8'h00));
    load(4'h3, ins(4'hD, 2'd0, 2'd0, 8'h02));
    load(4'h4, ins(4'hF, 2'd0, 2'd0, 8'h00));
    do_start();
    wait_halt(200, cyc);
    read_reg(2'd0, v);
    chk("loop_r0", v, 8'h00);
    chk("loop_zf", zf, 1);
    chk("loop_retired", retired, 9);
    chk("loop_cycles", cyc, 18);
    check_vs_model("loop");

    // random programs
    for (int t = 0; t < 25; t++) begin
      gen_random_prog();
      do_start();
      wait_halt(200, cyc);
      check_vs_model($sformatf("rnd%0d", t));
    end

    // write to address 0 in the same cycle as start
    load(4'h1, ins(4'hF, 2'd0, 2'd0, 8'h00));
    im_we = 1'b1; im_addr = 4'h0; im_wdata = ins(4'h1, 2'd3, 2'd0, 8'h77);
    m_mem[0] = im_wdata;
    start = 1'b1;
    tick();
    im_we = 1'b0; start = 1'b0;
    wait_halt(100, cyc);
    read_reg(2'd3, v);
    chk("wrstart_r3", v, 8'h77);
    check_vs_model("wrstart");

    // protection: writes and start pulses during a run are ignored
    load(4'h0, ins(4'h1, 2'd0, 2'd0, 8'h05));
    load(4'h1, ins(4'h1, 2'd1, 2'd0, 8'h03));
    load(4'h2, ins(4'h3, 2'd0, 2'd1, 8'h00));
    load(4'h3, ins(4'hF, 2'd0, 2'd0, 8'h00));
    do_start();
    im_we = 1'b1; im_addr = 4'h2; im_wdata = ins(4'hF, 2'd0, 2'd0, 8'h00);
    start = 1'b1;
    repeat (4) tick();
    im_we = 1'b0; start = 1'b0;
    wait_halt(100, cyc);
    read_reg(2'd0, v);
    chk("prot_r0", v, 8'h08);
    chk("prot_retired", retired, 4);
    check_vs_model("prot");
    load(4'h2, ins(4'h7, 2'd0, 2'd1, 8'h00));
    do_start();
    wait_halt(100, cyc);
    read_reg(2'd0, v);
    chk("prot_new_r0", v, 8'h06);
    check_vs_model("prot_new");

    // pc wrap over an all-NOP memory, then reset in EXEC
    for (int i = 0; i < 16; i++) load(4'(i), ins(4'h0, 2'd0, 2'd0, 8'h00));
    do_start();
    repeat (30) tick();
    chk("wrap_pc15", pc, 15);
    chk("wrap_ret15", retired, 15);
    repeat (2) tick();
    chk("wrap_pc0", pc, 0);
    chk("wrap_ret16", retired, 16);
    chk("wrap_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_flags", {zf, sf, cf}, 0);
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), v);
      chk($sformatf("midrst_r%0d", r), v, 0);
    end

    // wide configuration: 16-bit data, 8 registers, 64-word memory
    im_we_w = 1'b1;
    im_addr_w = 6'd0; im_wdata_w = {4'h1, 3'd7, 3'd0, 16'h8000}; tick();
    im_addr_w = 6'd1; im_wdata_w = {4'h8, 3'd7, 3'd0, 16'h0000}; tick();
    im_addr_w = 6'd2; im_wdata_w = {4'hF, 3'd0, 3'd0, 16'h0000}; tick();
    im_we_w = 1'b0;
    start_w = 1'b1; tick(); start_w = 1'b0;
    cyc = 0;
    while (halted_w !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("w_halted", halted_w, 1);
    dbg_sel_w = 3'd7; #1;
    chk("w_r7", dbg_data_w, 16'h0000);
    chk("w_cf", cf_w, 1);
    chk("w_zf", zf_w, 1);
    chk("w_sf", sf_w, 0);
    chk("w_retired", retired_w, 3);
    chk("w_pc", pc_w, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
